// File: rtl/controlador_de_jogo.sv
// controlador_de_jogo: debounces start/confirm buttons, sequences the attack manager, counts shots and decides win/loss
module controlador_de_jogo #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int MAX_ERROS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_iniciar,
  input  logic       btn_confirmar,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [6:0] matriz0,
  input  logic [6:0] matriz1,
  input  logic [6:0] matriz2,
  input  logic [6:0] matriz3,
  input  logic [6:0] matriz4,
  input  logic [2:0] vida,
  output logic       enable_out,
  output logic       confirmar_out,
  output logic [2:0] estado,
  output logic [5:0] jogadas,
  output logic       vitoria,
  output logic       derrota
);
  typedef enum logic [2:0] {
    OCIOSO  = 3'b000,
    ATAQUE  = 3'b001,
    DISPARO = 3'b010,
    AVALIA  = 3'b011,
    VITORIA = 3'b100,
    DERROTA = 3'b101
  } estado_t;
  estado_t state, next_state;
  logic [1:0] raw, s1, s2, acc, acc_d, ev;
  logic [15:0] cnt [2];
  logic [15:0] pulse_cnt;
  logic full_match;
  assign raw = {btn_confirmar, btn_iniciar};
  assign full_match = {matriz4, matriz3, matriz2, matriz1, matriz0} == {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign estado = state;
  assign vitoria = state == VITORIA;
  assign derrota = state == DERROTA;
  // bit 0 = iniciar, bit 1 = confirmar; ev is a registered one-cycle pulse on an accepted rising level
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      acc <= '0;
      acc_d <= '0;
      ev <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      acc_d <= acc;
      ev <= acc & ~acc_d;
      for (int i = 0; i < 2; i++)
        if (s2[i] == acc[i]) cnt[i] <= '0;
        else if (cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
          acc[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 16'd1;
    end
  always_comb begin
    next_state = OCIOSO;
    case (state)
      OCIOSO:  next_state = ev[0] ? ATAQUE : OCIOSO;
      ATAQUE:  next_state = ev[1] ? DISPARO : ATAQUE;
      DISPARO: next_state = (pulse_cnt == 16'(PULSE_CYCLES - 1)) ? AVALIA : DISPARO;
      AVALIA:  next_state = full_match ? VITORIA : (vida >= 3'(MAX_ERROS)) ? DERROTA : ATAQUE;
      VITORIA: next_state = ev[0] ? OCIOSO : VITORIA;
      DERROTA: next_state = ev[0] ? OCIOSO : DERROTA;
      default: next_state = OCIOSO;
    endcase
  end
  // enable/confirmar are flops decoded from next_state so they never glitch downstream
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= OCIOSO;
      pulse_cnt <= '0;
      jogadas <= '0;
      enable_out <= 1'b0;
      confirmar_out <= 1'b0;
    end else begin
      state <= next_state;
      enable_out <= next_state != OCIOSO;
      confirmar_out <= next_state == DISPARO;
      pulse_cnt <= (state == DISPARO) ? pulse_cnt + 16'd1 : '0;
      if (state == OCIOSO && next_state == ATAQUE) jogadas <= '0;
      else if (state == ATAQUE && next_state == DISPARO && jogadas != 6'd63) jogadas <= jogadas + 6'd1;
    end
endmodule

// File: doc/controlador_de_jogo.md
# controlador_de_jogo

Top-level game sequencer for the naval-battle board. It sits between the raw pushbuttons and the attack manager (`gerenciador_de_ataque`). It synchronises and debounces the start and confirm buttons, and drives the attack manager's `enable` and `confirmar` inputs with clean, timed levels. It counts shots and decides victory or defeat from the attack manager's 5×7 hit matrix and miss counter.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before a button level is accepted (range 1..65535).
- `PULSE_CYCLES`, 2: number of cycles `confirmar_out` stays high per accepted shot (≥1).
- `MAX_ERROS`, 3: miss count that ends the game in defeat (1..7).
- `clock` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `btn_iniciar` input 1: raw start button, active high, asynchronous to `clock`.
- `btn_confirmar` input 1: raw confirm button, active high, asynchronous to `clock`.
- `mapa0`..`mapa4` input 7 each: ship map, one word per column, bit n = row n.
- `matriz0`..`matriz4` input 7 each: hit matrix returned by the attack manager.
- `vida` input 3: miss count from the attack manager's life counter; 0 while `enable_out` is low.
- `enable_out` output 1: drives attack-manager `enable`.
- `confirmar_out` output 1: drives attack-manager `confirmar`.
- `estado` output 3: current FSM state code.
- `jogadas` output 6: accepted shots this game, saturating.
- `vitoria` output 1: high in VITORIA.
- `derrota` output 1: high in DERROTA.

## Operation
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer updates its accepted level only after `DEBOUNCE_CYCLES` consecutive identical synchronised samples.
  - A rising edge of an accepted level produces a one-cycle internal event: `ev_iniciar` or `ev_confirmar`.
- FSM states and codes:
  - OCIOSO 000: `enable_out`=0.
    - `ev_iniciar` → ATAQUE. `jogadas` clears to 0.
  - ATAQUE 001: `enable_out`=1.
    - `ev_confirmar` → DISPARO.
  - DISPARO 010: `enable_out`=1 and `confirmar_out`=1.
    - Stays for exactly `PULSE_CYCLES` cycles, then → AVALIA.
    - `jogadas` increments on entry; it saturates at 63.
  - AVALIA 011: `enable_out`=1. One cycle.
    - If every `matrizi` equals `mapai`, → VITORIA.
    - Otherwise, if `vida` ≥ `MAX_ERROS`, → DERROTA.
    - Otherwise → ATAQUE.
    - Victory has priority over defeat.
  - VITORIA 100 and DERROTA 101: `enable_out`=1, so the final board stays displayed.
    - `ev_iniciar` → OCIOSO.
  - Codes 110 and 111 are illegal and → OCIOSO on the next clock.
- Event filtering:
  - `ev_confirmar` is ignored outside ATAQUE. It is discarded, never queued.
  - `ev_iniciar` is ignored in ATAQUE, DISPARO and AVALIA.
- An empty map (all `mapai`=0) satisfies the victory test at the first AVALIA.
- `confirmar_out` is a registered output, glitch-free; it is used downstream as a clock edge.

## Timing
- Reset (`reset`=0), asynchronously:
  - State = OCIOSO; `enable_out`=0, `confirmar_out`=0, `jogadas`=0, `vitoria`=0, `derrota`=0, `estado`=000.
  - Synchroniser flops, debounce counters and accepted levels are all 0.
- Reset release takes effect at the first rising `clock` edge after `reset` goes high.
- Reset asserted mid-DISPARO drops `confirmar_out` immediately (asynchronously).
- Button latency: with a raw level held stable from edge k, the event is generated at edge k+2+`DEBOUNCE_CYCLES`. The state changes on the following edge.
- Shot sequence: `confirmar_out` is high for exactly `PULSE_CYCLES` cycles. It is followed by one AVALIA cycle, so the attack-manager flops have settled before evaluation.
- Back-to-back shots are limited by the debouncer. A held button produces one shot only; release and re-press is required.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles produces no event and no change to the accepted level.
- Returning from VITORIA/DERROTA drives `enable_out` low in OCIOSO, which clears the attack manager's matrix and miss counter. `jogadas` holds its value until the next start.

## Test plan
- Reset, then `btn_iniciar` high for 10 cycles (`DEBOUNCE_CYCLES`=4) → `estado` goes 000→001 at edge 7 after the press. `enable_out`=1, `jogadas`=0.
- In ATAQUE, one `btn_confirmar` press with 3-cycle bounce glitches, then a stable level → exactly one DISPARO, with `confirmar_out` high for 2 cycles. `jogadas`=1, then AVALIA→ATAQUE.
- `mapa0`=7'b0000001, other columns 0; model `matriz0` becoming 7'b0000001 after the pulse → AVALIA→VITORIA, `vitoria`=1, `enable_out` stays 1.
- Model `vida` reaching 3 with no full match → DERROTA, `derrota`=1. Then `btn_iniciar` → OCIOSO, `enable_out`=0.
- Full match and `vida`=3 in the same AVALIA → VITORIA, not DERROTA.
- Assert `reset` during the second DISPARO cycle → `confirmar_out` and `enable_out` fall without waiting for `clock`, `estado`=000, `jogadas`=0. A `btn_confirmar` press in OCIOSO leaves `jogadas`=0.
